// File: rtl/data_sync_tx.sv
// Source-domain sender: holds a word on unsync_bus and runs a four-phase
// req/ack handshake with a saturating ack timeout and a transfer counter.
module data_sync_tx #(
    parameter int BUS_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_ack,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [7:0]           o_tx_count
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_fired;
    logic          accept;

    // A stale ack left high in IDLE blocks new words until it drops.
    assign o_ready = (state == IDLE) && !i_ack;
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (i_ack) state_nxt = RELEASE;
            RELEASE: if (!i_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            o_tx_count <= 8'd0;
            tmo_cnt    <= '0;
            tmo_fired  <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unsync_bus <= i_data;
                        bus_enable <= 1'b1;
                        tmo_cnt    <= '0;
                        tmo_fired  <= 1'b0;
                    end
                end
                REQ: begin
                    // An ack on the timeout edge wins; the pulse is dropped.
                    if (i_ack) begin
                        bus_enable <= 1'b0;
                    end else if (tmo_cnt != TMAX) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end else if (!tmo_fired) begin
                        o_timeout <= 1'b1;
                        tmo_fired <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!i_ack) begin
                        o_done     <= 1'b1;
                        o_tx_count <= o_tx_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Self-checking bench for data_sync_tx: directed table, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_data_sync_tx;

    localparam int TMO = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       i_ack = 1'b0;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       o_done;
    logic       o_timeout;
    logic [7:0] o_tx_count;

    int total = 0;
    int bad = 0;

    data_sync_tx #(.BUS_WIDTH(8), .TIMEOUT(TMO)) dut (
        .CLK(CLK),
        .RST(RST),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_ack(i_ack),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable),
        .o_done(o_done),
        .o_timeout(o_timeout),
        .o_tx_count(o_tx_count)
    );

    always #5 CLK = ~CLK;

    // Reference model: a word is either being requested, being released,
    // or the sender is free. Age counts unacked edges since the request.
    bit         m_req;
    bit         m_rel;
    bit         m_done;
    bit         m_to;
    bit         m_acc;
    logic [7:0] m_bus;
    logic [7:0] m_cnt;
    int         m_age;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       rdy;
        logic [7:0] bus;
        logic       en;
        logic       done;
        logic       to;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic v, input logic [7:0] d,
                                input logic a, input logic rdy,
                                input logic [7:0] bus, input logic en,
                                input logic done, input logic to,
                                input logic [7:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.a = a; r.rdy = rdy; r.bus = bus;
        r.en = en; r.done = done; r.to = to; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_rel = 0; m_done = 0; m_to = 0; m_acc = 0;
        m_bus = 8'd0; m_cnt = 8'd0; m_age = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d,
                              input logic a);
        m_done = 0; m_to = 0; m_acc = 0;
        if (!m_req && !m_rel) begin
            if (v && !a) begin
                m_bus = d; m_req = 1; m_age = 0; m_acc = 1;
            end
        end else if (m_req) begin
            if (a) begin
                m_req = 0; m_rel = 1;
            end else begin
                m_age++;
                if (m_age == TMO + 1) m_to = 1;
            end
        end else if (!a) begin
            m_rel = 0; m_done = 1; m_cnt = m_cnt + 8'd1;
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input logic v, input logic [7:0] d,
                         input logic a);
        i_valid = v; i_data = d; i_ack = a;
        #1;
        chk("ready", {31'd0, o_ready}, {31'd0, !m_req && !m_rel && !a});
        @(posedge CLK);
        model_step(v, d, a);
        #1;
        chk("bus", {24'd0, unsync_bus}, {24'd0, m_bus});
        chk("enable", {31'd0, bus_enable}, {31'd0, m_req});
        chk("done", {31'd0, o_done}, {31'd0, m_done});
        chk("timeout", {31'd0, o_timeout}, {31'd0, m_to});
        chk("count", {24'd0, o_tx_count}, {24'd0, m_cnt});
        @(negedge CLK);
    endtask

    task automatic do_reset();
        i_valid = 0; i_ack = 0; i_data = 8'd0;
        RST = 0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1;
    endtask

    initial begin
        int dones;
        int pulses;
        int pulse_at;
        int idx;
        logic a;
        logic [7:0] words[$];

        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_bus", {24'd0, unsync_bus}, 32'd0);
        chk("rst_en", {31'd0, bus_enable}, 32'd0);
        chk("rst_cnt", {24'd0, o_tx_count}, 32'd0);
        RST = 1;

        // Single transfer of 0x3C, then a stale ack in IDLE.
        tbl[0]  = mk(1, 8'h3C, 0, 1, 8'h3C, 1, 0, 0, 8'd0);
        tbl[1]  = mk(0, 8'h00, 0, 0, 8'h3C, 1, 0, 0, 8'd0);
        tbl[2]  = mk(0, 8'h00, 0, 0, 8'h3C, 1, 0, 0, 8'd0);
        tbl[3]  = mk(0, 8'h00, 1, 0, 8'h3C, 0, 0, 0, 8'd0);
        tbl[4]  = mk(0, 8'h00, 1, 0, 8'h3C, 0, 0, 0, 8'd0);
        tbl[5]  = mk(0, 8'h00, 0, 0, 8'h3C, 0, 1, 0, 8'd1);
        tbl[6]  = mk(0, 8'h00, 0, 1, 8'h3C, 0, 0, 0, 8'd1);
        tbl[7]  = mk(1, 8'h77, 1, 0, 8'h3C, 0, 0, 0, 8'd1);
        tbl[8]  = mk(1, 8'h77, 0, 1, 8'h77, 1, 0, 0, 8'd1);
        tbl[9]  = mk(0, 8'h00, 1, 0, 8'h77, 0, 0, 0, 8'd1);
        tbl[10] = mk(0, 8'h00, 0, 0, 8'h77, 0, 1, 0, 8'd2);
        tbl[11] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 0, 8'd2);
        for (int i = 0; i < 12; i++) begin
            i_valid = tbl[i].v; i_data = tbl[i].d; i_ack = tbl[i].a;
            #1;
            chk("tbl_ready", {31'd0, o_ready}, {31'd0, tbl[i].rdy});
            cycle(tbl[i].v, tbl[i].d, tbl[i].a);
            chk("tbl_out",
                {20'd0, unsync_bus, bus_enable, o_done, o_timeout,
                 o_tx_count},
                {20'd0, tbl[i].bus, tbl[i].en, tbl[i].done, tbl[i].to,
                 tbl[i].cnt});
        end

        // Asynchronous reset in the middle of a request.
        cycle(1, 8'hA5, 0);
        cycle(0, 8'h00, 0);
        #2 RST = 0;
        #1;
        chk("arst_bus", {24'd0, unsync_bus}, 32'd0);
        chk("arst_en", {31'd0, bus_enable}, 32'd0);
        chk("arst_flags", {30'd0, o_done, o_timeout}, 32'd0);
        chk("arst_cnt", {24'd0, o_tx_count}, 32'd0);
        model_reset();
        @(negedge CLK);
        RST = 1;
        cycle(0, 8'h00, 0);

        // Withheld ack: exactly one timeout pulse, 5 edges after accept.
        cycle(1, 8'h5A, 0);
        pulses = 0; pulse_at = -1;
        for (int k = 1; k <= 9; k++) begin
            cycle(0, 8'h00, 0);
            if (o_timeout) begin
                pulses++;
                pulse_at = k;
            end
        end
        chk("tmo_pulses", pulses, 32'd1);
        chk("tmo_edge", pulse_at, TMO + 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        chk("tmo_count", {24'd0, o_tx_count}, 32'd1);

        // Ack arriving on the timeout edge suppresses the pulse.
        cycle(1, 8'hC3, 0);
        pulses = 0;
        for (int k = 1; k <= TMO; k++) cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 1);
        if (o_timeout) pulses++;
        cycle(0, 8'h00, 0);
        if (o_timeout) pulses++;
        chk("simul_pulses", pulses, 32'd0);
        chk("simul_count", {24'd0, o_tx_count}, 32'd2);

        // Back-to-back words 1..5 with an ack that follows the request.
        do_reset();
        dones = 0; idx = 1;
        for (int k = 0; k < 60 && dones < 5; k++) begin
            a = bus_enable;
            cycle(idx <= 5, 8'(idx), a);
            if (m_acc) begin
                words.push_back(8'(idx));
                idx++;
            end
            if (o_done) dones++;
        end
        chk("b2b_dones", dones, 32'd5);
        chk("b2b_count", {24'd0, o_tx_count}, 32'd5);
        chk("b2b_nwords", words.size(), 32'd5);
        for (int i = 0; i < words.size(); i++)
            chk("b2b_word", {24'd0, words[i]}, i + 1);

        // Randomized traffic, ack timing shaped by the model's phase.
        for (int k = 0; k < 1500; k++) begin
            if (m_req)      a = ($urandom % 8) == 0;
            else if (m_rel) a = ($urandom % 3) != 0;
            else            a = ($urandom % 10) == 0;
            cycle(1'($urandom % 2), 8'($urandom), a);
        end

        // Counter wrap after 256 transfers.
        do_reset();
        dones = 0;
        for (int k = 0; k < 2000 && dones < 256; k++) begin
            a = bus_enable;
            cycle(1, 8'(k), a);
            if (o_done) dones++;
            if (dones == 255 && o_done)
                chk("wrap_255", {24'd0, o_tx_count}, 32'd255);
        end
        chk("wrap_dones", dones, 32'd256);
        chk("wrap_zero", {24'd0, o_tx_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
